// File: rtl/top_color_tracker.sv
// Per-level jump/landing bookkeeping for the cube generators: keeps the coloured-top mask,
// its popcount, a sticky bad-index flag and the done_move / level_done handshake outputs.
module top_color_tracker #(
  parameter int N_cube        = 20,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump_start,
  input  logic              land_valid,
  input  logic [4:0]        land_idx,
  input  logic              toggle_mode,
  input  logic              level_clear,
  output logic [N_cube:0]   nios_top_color,
  output logic              done_move,
  output logic [4:0]        colored_cnt,
  output logic              level_done,
  output logic              idx_err
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_JUMP,
    S_UPDATE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [N_cube:0]   r_mask;
  logic [4:0]        r_cnt;
  logic [4:0]        r_idx;
  logic              r_tog;
  logic              r_err;
  logic              r_done_move;
  logic              r_level_done;
  logic [SW-1:0]     r_settle;

  logic [N_cube:0]   w_onehot;
  logic              w_legal;
  logic              w_was_set;

  // The one-hot is only applied when the latched index is legal, so an
  // out-of-range shift that falls off the top is harmless.
  assign w_onehot  = {{N_cube{1'b0}}, 1'b1} << r_idx;
  assign w_legal   = (r_idx <= 5'(N_cube));
  assign w_was_set = |(r_mask & w_onehot);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_tog        <= 1'b0;
      r_err        <= 1'b0;
      r_done_move  <= 1'b1;
      r_level_done <= 1'b0;
      r_settle     <= '0;
    end else if (level_clear) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_done_move  <= 1'b1;
      r_level_done <= 1'b0;
      r_settle     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (jump_start) begin
            r_state     <= S_JUMP;
            r_done_move <= 1'b0;
          end
        end
        S_JUMP: begin
          if (land_valid) begin
            r_idx   <= land_idx;
            r_tog   <= toggle_mode;
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!w_legal) begin
            r_err <= 1'b1;
          end else if (r_tog) begin
            r_mask <= r_mask ^ w_onehot;
            r_cnt  <= w_was_set ? (r_cnt - 5'd1) : (r_cnt + 5'd1);
          end else if (!w_was_set) begin
            r_mask <= r_mask | w_onehot;
            r_cnt  <= r_cnt + 5'd1;
          end
          r_settle <= SW'(SETTLE_CYCLES - 1);
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            r_done_move <= 1'b1;
            if (&r_mask) begin
              r_state      <= S_DONE;
              r_level_done <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign nios_top_color = r_mask;
  assign done_move      = r_done_move;
  assign colored_cnt    = r_cnt;
  assign level_done     = r_level_done;
  assign idx_err        = r_err;

endmodule

// File: tb/tb_top_color_tracker.sv
// Bench for top_color_tracker: event-timed reference model with a per-cycle compare,
// directed scenarios with literal expectations, then a randomized pulse phase.
module tb_top_color_tracker;

  localparam int N  = 20;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          jump_start = 1'b0;
  logic          land_valid = 1'b0;
  logic [4:0]    land_idx = '0;
  logic          toggle_mode = 1'b0;
  logic          level_clear = 1'b0;
  logic [N:0]    nios_top_color;
  logic          done_move;
  logic [4:0]    colored_cnt;
  logic          level_done;
  logic          idx_err;

  int total = 0;
  int bad   = 0;

  top_color_tracker #(.N_cube(N), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .jump_start(jump_start), .land_valid(land_valid),
    .land_idx(land_idx), .toggle_mode(toggle_mode), .level_clear(level_clear),
    .nios_top_color(nios_top_color), .done_move(done_move), .colored_cnt(colored_cnt),
    .level_done(level_done), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a jump is "in flight" from acceptance until its release edge;
  // a landing schedules the mask change one edge later and the release SC edges after that.
  logic [N:0] m_mask;
  logic       m_err, m_busy, m_landed, m_done, m_ptog;
  int         m_pidx, m_cyc, m_apply, m_rel;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_mask = '0; m_err = 0; m_busy = 0; m_landed = 0; m_done = 0;
        m_ptog = 0; m_pidx = 0; m_cyc = 0; m_apply = -1; m_rel = -1;
      end else begin
        m_cyc++;
        if (level_clear) begin
          m_mask = '0; m_err = 0; m_busy = 0; m_landed = 0; m_done = 0;
        end else begin
          automatic logic can_jump = !m_busy && !m_done;
          automatic logic can_land = m_busy && !m_landed;
          if (m_landed && m_cyc == m_apply) begin
            if (m_pidx > N) m_err = 1;
            else if (m_ptog) m_mask[m_pidx] = ~m_mask[m_pidx];
            else m_mask[m_pidx] = 1'b1;
          end
          if (m_landed && m_cyc == m_rel) begin
            m_busy = 0;
            m_landed = 0;
            if (m_mask == {(N+1){1'b1}}) m_done = 1;
          end
          if (can_jump && jump_start) m_busy = 1;
          if (can_land && land_valid) begin
            m_landed = 1;
            m_pidx   = int'(land_idx);
            m_ptog   = toggle_mode;
            m_apply  = m_cyc + 1;
            m_rel    = m_cyc + 1 + SC;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("mask", 32'(nios_top_color), 32'(m_mask));
        check("cnt", 32'(colored_cnt), 32'($countones(m_mask)));
        check("done_move", 32'(done_move), 32'(!m_busy));
        check("level_done", 32'(level_done), 32'(m_done));
        check("idx_err", 32'(idx_err), 32'(m_err));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    level_clear = 1; tick(); level_clear = 0;
  endtask

  // Full jump/landing transaction with literal handshake timing checks.
  task automatic land(input int idx, input logic tog);
    jump_start = 1; tick(); jump_start = 0;
    check("jump_lowers_done_move", 32'(done_move), 32'd0);
    repeat (4) tick();
    land_valid = 1; land_idx = 5'(idx); toggle_mode = tog;
    tick();
    land_valid = 0; toggle_mode = 0;
    repeat (SC) tick();
    check("done_move_still_low", 32'(done_move), 32'd0);
    tick();
    check("done_move_release", 32'(done_move), 32'd1);
    $display("land idx=%0d tog=%0d -> mask=%06h cnt=%0d err=%0d", idx, tog, nios_top_color, colored_cnt, idx_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    repeat (3) tick();
    check("rst_mask", 32'(nios_top_color), 32'd0);
    check("rst_done_move", 32'(done_move), 32'd1);
    check("rst_cnt", 32'(colored_cnt), 32'd0);
    check("rst_level_done", 32'(level_done), 32'd0);
    reset = 1;
    tick();
    land_valid = 1; land_idx = 5'd3; tick(); land_valid = 0;
    tick();
    check("idle_land_ignored", 32'(nios_top_color), 32'd0);

    land(7, 0);
    check("set7_mask", 32'(nios_top_color), 32'h80);
    check("set7_cnt", 32'(colored_cnt), 32'd1);
    land(7, 0);
    check("reset7_cnt", 32'(colored_cnt), 32'd1);

    pulse_clear();
    land(2, 0);
    land(2, 1);
    check("toggle_mask", 32'(nios_top_color), 32'd0);
    check("toggle_cnt", 32'(colored_cnt), 32'd0);

    land(25, 0);
    check("illegal_mask", 32'(nios_top_color), 32'd0);
    check("illegal_err", 32'(idx_err), 32'd1);
    land(4, 0);
    check("err_sticky", 32'(idx_err), 32'd1);
    pulse_clear();
    check("err_cleared", 32'(idx_err), 32'd0);

    for (int i = 0; i <= N; i++) land(i, 0);
    check("full_level_done", 32'(level_done), 32'd1);
    check("full_cnt", 32'(colored_cnt), 32'd21);
    check("full_mask", 32'(nios_top_color), 32'h1FFFFF);
    jump_start = 1; tick(); jump_start = 0; tick();
    check("done_ignores_jump", 32'(done_move), 32'd1);

    pulse_clear();
    jump_start = 1; tick(); jump_start = 0; tick();
    land_valid = 1; land_idx = 5'd9; level_clear = 1; tick();
    land_valid = 0; level_clear = 0;
    check("clr_land_mask", 32'(nios_top_color), 32'd0);
    check("clr_land_done_move", 32'(done_move), 32'd1);
    tick(); tick();
    check("clr_land_no_bit", 32'(nios_top_color), 32'd0);

    jump_start = 1; tick(); jump_start = 0;
    land_valid = 1; land_idx = 5'd5; tick(); land_valid = 0;
    tick(); tick();
    check("midsettle_bit5", 32'(nios_top_color), 32'h20);
    pulse_clear();
    check("clr_settle_mask", 32'(nios_top_color), 32'd0);
    check("clr_settle_cnt", 32'(colored_cnt), 32'd0);
    check("clr_settle_done_move", 32'(done_move), 32'd1);

    jump_start = 1; tick(); jump_start = 0;
    land_valid = 1; land_idx = 5'd6; tick(); land_valid = 0;
    tick(); tick();
    reset = 0; #1;
    check("rst_settle_mask", 32'(nios_top_color), 32'd0);
    check("rst_settle_cnt", 32'(colored_cnt), 32'd0);
    check("rst_settle_done_move", 32'(done_move), 32'd1);
    tick(); tick();
    reset = 1;
    tick();

    for (int c = 0; c < 3000; c++) begin
      jump_start  = ($urandom_range(0, 3) == 0);
      land_valid  = ($urandom_range(0, 2) == 0);
      land_idx    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, N));
      toggle_mode = ($urandom_range(0, 3) == 0);
      level_clear = ($urandom_range(0, 150) == 0);
      tick();
    end
    jump_start = 0; land_valid = 0; level_clear = 0; toggle_mode = 0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
